// File: rtl/b1_scfifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module   : b1_scfifo_rd_stream
//  Brief    : Read-side adapter for b1_scfifo. Drains the FIFO through
//             rdreq/q/empty into a 2-entry registered buffer and presents it
//             as a valid/ready stream. Supports SHOWAHEAD "ON" and "OFF".
//             Optional statistics counters are built when the macro
//             B1_RDSTREAM_STATS_EN is defined; otherwise both outputs are 0.
//  Revision : 1.0 - initial release
// ============================================================================
module b1_scfifo_rd_stream #(
   parameter int    DWIDTH    = 8,
   parameter string SHOWAHEAD = "ON",
   parameter int    CWIDTH    = 16
) (
   input  logic              clk_i,
   input  logic              arst_n_i,
   input  logic              fifo_empty_i,
   input  logic [DWIDTH-1:0] fifo_q_i,
   output logic              fifo_rdreq_o,
   output logic [DWIDTH-1:0] out_data_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CWIDTH-1:0] xfer_cnt_o,
   output logic [CWIDTH-1:0] stall_cnt_o
);

   localparam bit c_SHOWAHEAD_OFF = (SHOWAHEAD == "OFF");

   // Buffer state: head slot drives the stream, tail slot holds the second word.
   logic [1:0]        occ_q, occ_d;
   logic [DWIDTH-1:0] head_q, head_d;
   logic [DWIDTH-1:0] tail_q, tail_d;

   logic       w_xfer;
   logic       w_push;
   logic       w_inf;
   logic [2:0] w_cred;

   assign out_valid_o = (occ_q != 2'd0);
   assign out_data_o  = head_q;
   assign w_xfer      = out_valid_o & out_ready_i;

   // Free slots, counting a word still in flight as occupied and a word
   // leaving this cycle as already free. occ+inf never exceeds 2.
   assign w_cred = 3'd2 - {1'b0, occ_q} - {2'b00, w_inf} + {2'b00, w_xfer};

   // Reset gating keeps the FIFO untouched while the adapter is held in reset.
   assign fifo_rdreq_o = ~fifo_empty_i & (w_cred != 3'd0) & arst_n_i;

   generate
      if (c_SHOWAHEAD_OFF) begin : g_showahead_off
         logic inf_q;
         // Word requested last cycle appears on fifo_q_i this cycle.
         always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i) begin
               inf_q <= 1'b0;
            end else begin
               inf_q <= fifo_rdreq_o;
            end
         end
         assign w_inf  = inf_q;
         assign w_push = inf_q;
      end else begin : g_showahead_on
         // Look-ahead data is valid with the request itself.
         assign w_inf  = 1'b0;
         assign w_push = fifo_rdreq_o;
      end
   endgenerate

   // Next buffer contents: push into the first free slot, pop shifts tail to head.
   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      case (occ_q)
         2'd0: begin
            if (w_push) begin
               head_d = fifo_q_i;
               occ_d  = 2'd1;
            end
         end
         2'd1: begin
            case ({w_push, w_xfer})
               2'b10: begin
                  tail_d = fifo_q_i;
                  occ_d  = 2'd2;
               end
               2'b11: head_d = fifo_q_i;
               2'b01: occ_d  = 2'd0;
               default: ;
            endcase
         end
         default: begin
            // Credit guarantees no push into a full buffer without a pop.
            if (w_xfer) begin
               head_d = tail_q;
               if (w_push) begin
                  tail_d = fifo_q_i;
               end else begin
                  occ_d = 2'd1;
               end
            end
         end
      endcase
   end

   // Buffer registers; reset discards every buffered word.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         occ_q  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         occ_q  <= occ_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

`ifdef B1_RDSTREAM_STATS_EN
   localparam logic [CWIDTH-1:0] c_CNT_ONE = {{(CWIDTH-1){1'b0}}, 1'b1};

   logic [CWIDTH-1:0] xfer_cnt_q;
   logic [CWIDTH-1:0] stall_cnt_q;

   // Free-running statistics, wrapping naturally at 2^CWIDTH.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         xfer_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (w_xfer) begin
            xfer_cnt_q <= xfer_cnt_q + c_CNT_ONE;
         end
         if (out_valid_o && !out_ready_i) begin
            stall_cnt_q <= stall_cnt_q + c_CNT_ONE;
         end
      end
   end

   assign xfer_cnt_o  = xfer_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
`else
   assign xfer_cnt_o  = '0;
   assign stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_b1_scfifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_b1_scfifo_rd_stream
//  Brief    : Directed bench for b1_scfifo_rd_stream. One instance in each
//             SHOWAHEAD mode, each fed by a small behavioural FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_b1_scfifo_rd_stream;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   logic flush = 1'b1;

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // ---------------- SHOWAHEAD "ON" instance (a) ----------------
   logic [7:0]  mem_a [0:1023];
   int          wr_a = 0, rd_a = 0, ovr_a = 0;
   logic        a_empty, a_rdreq, a_valid, a_ready = 1'b0;
   logic [7:0]  a_q, a_data;
   logic [15:0] a_xcnt, a_scnt;

   assign a_empty = (wr_a == rd_a);
   assign a_q     = mem_a[rd_a[9:0]];

   always @(posedge clk) begin
      if (flush) rd_a <= wr_a;
      else if (a_rdreq && !a_empty) rd_a <= rd_a + 1;
      if (a_rdreq && a_empty) ovr_a <= ovr_a + 1;
   end

   b1_scfifo_rd_stream #(.DWIDTH(8), .SHOWAHEAD("ON"), .CWIDTH(16)) u_dut_on (
      .clk_i(clk), .arst_n_i(arst_n), .fifo_empty_i(a_empty), .fifo_q_i(a_q),
      .fifo_rdreq_o(a_rdreq), .out_data_o(a_data), .out_valid_o(a_valid),
      .out_ready_i(a_ready), .xfer_cnt_o(a_xcnt), .stall_cnt_o(a_scnt)
   );

   // ---------------- SHOWAHEAD "OFF" instance (b) ----------------
   logic [7:0]  mem_b [0:1023];
   int          wr_b = 0, rd_b = 0, ovr_b = 0;
   logic        b_empty, b_rdreq, b_valid, b_ready = 1'b0;
   logic [7:0]  b_q = 8'h00, b_data;
   logic [15:0] b_xcnt, b_scnt;

   assign b_empty = (wr_b == rd_b);

   always @(posedge clk) begin
      if (flush) rd_b <= wr_b;
      else if (b_rdreq && !b_empty) begin
         rd_b <= rd_b + 1;
         b_q  <= mem_b[rd_b[9:0]];
      end
      if (b_rdreq && b_empty) ovr_b <= ovr_b + 1;
   end

   b1_scfifo_rd_stream #(.DWIDTH(8), .SHOWAHEAD("OFF"), .CWIDTH(16)) u_dut_off (
      .clk_i(clk), .arst_n_i(arst_n), .fifo_empty_i(b_empty), .fifo_q_i(b_q),
      .fifo_rdreq_o(b_rdreq), .out_data_o(b_data), .out_valid_o(b_valid),
      .out_ready_i(b_ready), .xfer_cnt_o(b_xcnt), .stall_cnt_o(b_scnt)
   );

   task automatic push_a(input logic [7:0] v);
      mem_a[wr_a[9:0]] = v;
      wr_a = wr_a + 1;
   endtask

   task automatic push_b(input logic [7:0] v);
      mem_b[wr_b[9:0]] = v;
      wr_b = wr_b + 1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      arst_n = 1'b0;
      flush  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      arst_n = 1'b1;
      flush  = 1'b0;
   endtask

   // Outputs while held in reset, then release.
   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      n_vec++;
      if ({a_valid, a_rdreq, a_data, a_xcnt, a_scnt} !== 35'd0) begin
         n_err++;
         $display("FAIL reset_on: got v=%b r=%b d=%h x=%0d s=%0d want all 0",
                  a_valid, a_rdreq, a_data, a_xcnt, a_scnt);
      end
      n_vec++;
      if ({b_valid, b_rdreq, b_data, b_xcnt, b_scnt} !== 35'd0) begin
         n_err++;
         $display("FAIL reset_off: got v=%b r=%b d=%h x=%0d s=%0d want all 0",
                  b_valid, b_rdreq, b_data, b_xcnt, b_scnt);
      end
      @(negedge clk);
      arst_n = 1'b1;
      flush  = 1'b0;
   endtask

   // Empty FIFOs: no reads and no stream activity.
   task automatic test_idle();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         n_vec++;
         if ({a_rdreq, a_valid, b_rdreq, b_valid} !== 4'b0000) begin
            n_err++;
            $display("FAIL idle cycle %0d: got rdreq/valid a=%b%b b=%b%b want 0000",
                     i, a_rdreq, a_valid, b_rdreq, b_valid);
         end
      end
   endtask

   // 256 words, latency 1, one word per cycle.
   task automatic test_on_stream();
      logic [7:0] e;
      @(negedge clk);
      a_ready = 1'b1;
      for (int i = 0; i < 256; i++) push_a(8'(i));
      #1;
      n_vec++;
      if ({a_rdreq, a_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL on_first_cycle: got rdreq=%b valid=%b want rdreq=1 valid=0",
                  a_rdreq, a_valid);
      end
      for (int k = 0; k < 256; k++) begin
         @(negedge clk);
         #1;
         e = 8'(k);
         n_vec++;
         if ({a_valid, a_data} !== {1'b1, e}) begin
            n_err++;
            $display("FAIL on_stream word %0d: got valid=%b data=%h want valid=1 data=%h",
                     k, a_valid, a_data, e);
         end
      end
      @(negedge clk);
      #1;
      n_vec++;
      if (a_valid !== 1'b0 || ovr_a != 0) begin
         n_err++;
         $display("FAIL on_drain: got valid=%b overreads=%0d want valid=0 overreads=0",
                  a_valid, ovr_a);
      end
   endtask

   // Stalled consumer: two fetches, head held, then three back-to-back transfers.
   task automatic test_backpressure();
      logic [7:0] exp [3];
      int pulses;
      exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
      pulses = 0;
      @(negedge clk);
      a_ready = 1'b0;
      push_a(8'h11); push_a(8'h22); push_a(8'h33);
      for (int i = 0; i < 10; i++) begin
         #1;
         if (a_rdreq) pulses++;
         if (i >= 1) begin
            n_vec++;
            if ({a_valid, a_data} !== {1'b1, 8'h11}) begin
               n_err++;
               $display("FAIL bp_hold cycle %0d: got valid=%b data=%h want valid=1 data=11",
                        i, a_valid, a_data);
            end
         end
         @(negedge clk);
      end
      n_vec++;
      if (pulses != 2) begin
         n_err++;
         $display("FAIL bp_rdreq_pulses: got %0d want 2", pulses);
      end
      a_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_vec++;
         if ({a_valid, a_data} !== {1'b1, exp[k]}) begin
            n_err++;
            $display("FAIL bp_release word %0d: got valid=%b data=%h want valid=1 data=%h",
                     k, a_valid, a_data, exp[k]);
         end
         @(negedge clk);
      end
      #1;
      n_vec++;
      if (a_valid !== 1'b0) begin
         n_err++;
         $display("FAIL bp_after: got valid=%b want 0", a_valid);
      end
   endtask

   // OFF mode: valid rises two cycles after rdreq.
   task automatic test_off_latency();
      @(negedge clk);
      b_ready = 1'b1;
      push_b(8'hA5);
      #1;
      n_vec++;
      if ({b_rdreq, b_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL off_lat_n: got rdreq=%b valid=%b want 1 0", b_rdreq, b_valid);
      end
      @(negedge clk);
      #1;
      n_vec++;
      if ({b_rdreq, b_valid} !== 2'b00) begin
         n_err++;
         $display("FAIL off_lat_n1: got rdreq=%b valid=%b want 0 0", b_rdreq, b_valid);
      end
      @(negedge clk);
      #1;
      n_vec++;
      if ({b_valid, b_data} !== {1'b1, 8'hA5}) begin
         n_err++;
         $display("FAIL off_lat_n2: got valid=%b data=%h want valid=1 data=a5",
                  b_valid, b_data);
      end
      @(negedge clk);
      #1;
      n_vec++;
      if (b_valid !== 1'b0) begin
         n_err++;
         $display("FAIL off_lat_after: got valid=%b want 0", b_valid);
      end
   endtask

   // OFF mode, 64 words, random ready: exact order, stable head while stalled.
   task automatic test_off_random();
      logic [7:0] exp [64];
      int got, cyc;
      for (int i = 0; i < 64; i++) exp[i] = 8'(i * 3 + 7);
      got = 0;
      cyc = 0;
      @(negedge clk);
      for (int i = 0; i < 64; i++) push_b(exp[i]);
      while (got < 64 && cyc < 2000) begin
         @(negedge clk);
         b_ready = 1'($urandom_range(0, 1));
         #1;
         if (b_valid) begin
            n_vec++;
            if (b_data !== exp[got]) begin
               n_err++;
               $display("FAIL off_rand word %0d (ready=%b): got %h want %h",
                        got, b_ready, b_data, exp[got]);
            end
            if (b_ready) got++;
         end
         cyc++;
      end
      n_vec++;
      if (got != 64 || ovr_b != 0) begin
         n_err++;
         $display("FAIL off_rand_count: got %0d words, %0d overreads want 64, 0", got, ovr_b);
      end
      @(negedge clk);
      b_ready = 1'b1;
      #1;
      n_vec++;
      if ({b_valid, b_rdreq} !== 2'b00) begin
         n_err++;
         $display("FAIL off_rand_dup: got valid=%b rdreq=%b want 0 0", b_valid, b_rdreq);
      end
   endtask

   // Asynchronous reset with a full buffer, then resume.
   task automatic test_async_reset();
      @(negedge clk);
      a_ready = 1'b0;
      push_a(8'h5A); push_a(8'hC3); push_a(8'h77);
      repeat (3) @(negedge clk);
      #1;
      n_vec++;
      if ({a_valid, a_data, a_rdreq} !== {1'b1, 8'h5A, 1'b0}) begin
         n_err++;
         $display("FAIL areset_pre: got valid=%b data=%h rdreq=%b want 1 5a 0",
                  a_valid, a_data, a_rdreq);
      end
      #2;
      arst_n = 1'b0;
      flush  = 1'b1;
      #1;
      n_vec++;
      if ({a_valid, a_rdreq, a_data} !== 10'd0) begin
         n_err++;
         $display("FAIL areset_immediate: got valid=%b rdreq=%b data=%h want 0 0 00",
                  a_valid, a_rdreq, a_data);
      end
      @(negedge clk);
      @(negedge clk);
      arst_n  = 1'b1;
      flush   = 1'b0;
      a_ready = 1'b1;
      for (int i = 1; i <= 4; i++) push_a(8'(i));
      #1;
      n_vec++;
      if ({a_rdreq, a_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL areset_first_rdreq: got rdreq=%b valid=%b want 1 0", a_rdreq, a_valid);
      end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         #1;
         n_vec++;
         if ({a_valid, a_data} !== {1'b1, 8'(k)}) begin
            n_err++;
            $display("FAIL areset_resume word %0d: got valid=%b data=%h want valid=1 data=%h",
                     k, a_valid, a_data, 8'(k));
         end
      end
   endtask

   // 100 transfers with exactly 20 stall cycles.
   task automatic test_stats();
      int got, stalls, cyc;
      logic [15:0] ex_x, ex_s;
      do_reset();
      got = 0;
      stalls = 0;
      cyc = 0;
      a_ready = 1'b1;
      for (int i = 0; i < 100; i++) push_a(8'(i + 100));
      while (got < 100 && cyc < 1000) begin
         @(negedge clk);
         if (a_valid && stalls < 20 && (cyc % 4) == 1) begin
            a_ready = 1'b0;
            stalls++;
         end else begin
            a_ready = 1'b1;
         end
         #1;
         if (a_valid && a_ready) begin
            n_vec++;
            if (a_data !== 8'(got + 100)) begin
               n_err++;
               $display("FAIL stats_data word %0d: got %h want %h", got, a_data, 8'(got + 100));
            end
            got++;
         end
         cyc++;
      end
      @(negedge clk);
      a_ready = 1'b1;
      #1;
`ifdef B1_RDSTREAM_STATS_EN
      ex_x = 16'd100;
      ex_s = 16'd20;
`else
      ex_x = 16'd0;
      ex_s = 16'd0;
`endif
      n_vec++;
      if (a_xcnt !== ex_x || got != 100) begin
         n_err++;
         $display("FAIL stats_xfer: got cnt=%0d (words %0d) want cnt=%0d (words 100)",
                  a_xcnt, got, ex_x);
      end
      n_vec++;
      if (a_scnt !== ex_s) begin
         n_err++;
         $display("FAIL stats_stall: got %0d want %0d", a_scnt, ex_s);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_idle();
      test_on_stream();
      test_backpressure();
      test_off_latency();
      test_off_random();
      test_async_reset();
      test_stats();
      n_vec++;
      if (ovr_a != 0 || ovr_b != 0) begin
         n_err++;
         $display("FAIL overread_total: got a=%0d b=%0d want 0 0", ovr_a, ovr_b);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
